// File: rtl/axi4_slave_mem.sv
// AXI4 slave backed by a word array: INCR write and read bursts with OKAY/SLVERR.
// The write and read channels are independent FSMs that share only the memory.
module axi4_slave_mem #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 16,
   parameter int MEM_DEPTH = 1024
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic [ADDR_W-1:0] AWADDR,
   input  logic [7:0]        AWLEN,
   input  logic [2:0]        AWSIZE,
   input  logic              AWVALID,
   output logic              AWREADY,
   input  logic [DATA_W-1:0] WDATA,
   input  logic              WVALID,
   input  logic              WLAST,
   output logic              WREADY,
   output logic [1:0]        BRESP,
   output logic              BVALID,
   input  logic              BREADY,
   input  logic [ADDR_W-1:0] ARADDR,
   input  logic [7:0]        ARLEN,
   input  logic [2:0]        ARSIZE,
   input  logic              ARVALID,
   output logic              ARREADY,
   output logic [DATA_W-1:0] RDATA,
   output logic [1:0]        RRESP,
   output logic              RLAST,
   output logic              RVALID,
   input  logic              RREADY
);
   localparam int IDX_W = $clog2(MEM_DEPTH);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
   typedef enum logic       {R_IDLE, R_DATA} rstate_t;

   logic [DATA_W-1:0] mem [MEM_DEPTH];

   // Byte span is computed inside the 4 KB page so a crossing shows up as a carry out of bit 11.
   function automatic logic burst_err(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                                      input logic [2:0] size);
      logic [12:0]       span;
      logic [12:0]       pg_end;
      logic [ADDR_W-1:0] last;
      span   = 13'(len) << size[1:0];
      pg_end = {1'b0, addr[11:0]} + span;
      last   = addr + ADDR_W'(span);
      burst_err = (size > 3'd2) ||
                  (size == 3'd1 && addr[0]) ||
                  (size == 3'd2 && addr[1:0] != 2'b00) ||
                  (int'(last[ADDR_W-1:2]) >= MEM_DEPTH) ||
                  pg_end[12];
   endfunction

   // ---------------- write channel ----------------
   wstate_t           w_state, w_next;
   logic [ADDR_W-1:0] w_addr;
   logic [7:0]        w_len;
   logic [2:0]        w_size;
   logic [8:0]        w_cnt;
   logic              w_err;
   logic              w_last_beat, w_hs, mem_we;

   assign w_last_beat = (w_cnt == {1'b0, w_len});
   assign w_hs        = WVALID && WREADY;
   assign mem_we      = w_hs && !w_err;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) w_state <= W_IDLE;
      else          w_state <= w_next;
   end

   always_comb begin
      w_next  = w_state;
      AWREADY = 1'b0;
      WREADY  = 1'b0;
      BVALID  = 1'b0;
      BRESP   = 2'b00;
      case (w_state)
         W_IDLE: begin
            AWREADY = 1'b1;
            if (AWVALID) w_next = W_DATA;
         end
         W_DATA: begin
            WREADY = 1'b1;
            if (WVALID && w_last_beat) w_next = W_RESP;
         end
         W_RESP: begin
            BVALID = 1'b1;
            BRESP  = w_err ? 2'b10 : 2'b00;
            if (BREADY) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         w_addr <= '0;
         w_len  <= '0;
         w_size <= '0;
         w_cnt  <= '0;
         w_err  <= 1'b0;
      end else if (AWVALID && AWREADY) begin
         w_addr <= AWADDR;
         w_len  <= AWLEN;
         w_size <= AWSIZE;
         w_cnt  <= '0;
         w_err  <= burst_err(AWADDR, AWLEN, AWSIZE);
      end else if (w_hs) begin
         w_addr <= w_addr + (ADDR_W'(1) << w_size);
         w_cnt  <= w_cnt + 9'd1;
         // WLAST only flags protocol errors; the beat count still ends the burst
         if (WLAST != w_last_beat) w_err <= 1'b1;
      end
   end

   always_ff @(posedge ACLK) begin
      if (mem_we) mem[w_addr[IDX_W+1:2]] <= WDATA;
   end

   // ---------------- read channel ----------------
   rstate_t           r_state, r_next;
   logic [ADDR_W-1:0] r_addr, r_nxt;
   logic [7:0]        r_len;
   logic [2:0]        r_size;
   logic [8:0]        r_cnt;
   logic              r_err, ar_err;

   assign r_nxt  = r_addr + (ADDR_W'(1) << r_size);
   assign ar_err = burst_err(ARADDR, ARLEN, ARSIZE);

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) r_state <= R_IDLE;
      else          r_state <= r_next;
   end

   always_comb begin
      r_next  = r_state;
      ARREADY = 1'b0;
      case (r_state)
         R_IDLE: begin
            ARREADY = 1'b1;
            if (ARVALID) r_next = R_DATA;
         end
         R_DATA: if (RREADY && RLAST) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   // Beats load straight from the array, so a same-edge write to that word is not yet visible.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_addr <= '0;
         r_len  <= '0;
         r_size <= '0;
         r_cnt  <= '0;
         r_err  <= 1'b0;
         RVALID <= 1'b0;
         RLAST  <= 1'b0;
         RRESP  <= 2'b00;
         RDATA  <= '0;
      end else if (ARVALID && ARREADY) begin
         r_addr <= ARADDR;
         r_len  <= ARLEN;
         r_size <= ARSIZE;
         r_cnt  <= '0;
         r_err  <= ar_err;
         RVALID <= 1'b1;
         RLAST  <= (ARLEN == 8'd0);
         RRESP  <= ar_err ? 2'b10 : 2'b00;
         RDATA  <= ar_err ? '0 : mem[ARADDR[IDX_W+1:2]];
      end else if (RVALID && RREADY) begin
         if (RLAST) begin
            RVALID <= 1'b0;
            RLAST  <= 1'b0;
         end else begin
            r_addr <= r_nxt;
            r_cnt  <= r_cnt + 9'd1;
            RLAST  <= (r_cnt + 9'd1 == {1'b0, r_len});
            RDATA  <= r_err ? '0 : mem[r_nxt[IDX_W+1:2]];
         end
      end
   end
endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed bench for axi4_slave_mem: bursts, error responses, read backpressure, mid-burst reset.
module tb_axi4_slave_mem;
   logic        ACLK = 1'b0;
   logic        ARESETn;
   logic [15:0] AWADDR;
   logic [7:0]  AWLEN;
   logic [2:0]  AWSIZE;
   logic        AWVALID, AWREADY;
   logic [31:0] WDATA;
   logic        WVALID, WLAST, WREADY;
   logic [1:0]  BRESP;
   logic        BVALID, BREADY;
   logic [15:0] ARADDR;
   logic [7:0]  ARLEN;
   logic [2:0]  ARSIZE;
   logic        ARVALID, ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RLAST, RVALID, RREADY;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] wd [0:15];
   logic [31:0] rx [0:15];

   axi4_slave_mem #(.DATA_W(32), .ADDR_W(16), .MEM_DEPTH(1024)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
   );

   always #5 ACLK = ~ACLK;

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // bad >= 0 moves WLAST onto that beat instead of the final one
   task automatic wr(input string tag, input logic [15:0] a, input int len, input logic [2:0] sz,
                     input int bad, input logic [1:0] exp_resp);
      AWADDR = a; AWLEN = 8'(len); AWSIZE = sz; AWVALID = 1'b1;
      chk({tag, " awready"}, 32'(AWREADY), 32'd1);
      tick();
      AWVALID = 1'b0;
      for (int i = 0; i <= len; i++) begin
         chk($sformatf("%s wready%0d", tag, i), 32'(WREADY), 32'd1);
         WDATA = wd[i]; WVALID = 1'b1;
         WLAST = (bad >= 0) ? (i == bad) : (i == len);
         tick();
      end
      WVALID = 1'b0; WLAST = 1'b0;
      chk({tag, " wready_off"}, 32'(WREADY), 32'd0);
      chk({tag, " bvalid"}, 32'(BVALID), 32'd1);
      chk({tag, " bresp"}, 32'(BRESP), 32'(exp_resp));
      BREADY = 1'b1;
      tick();
      BREADY = 1'b0;
      chk({tag, " bvalid_off"}, 32'(BVALID), 32'd0);
      chk({tag, " awready_back"}, 32'(AWREADY), 32'd1);
   endtask

   // toggle inserts a stalled cycle before every even beat
   task automatic rd(input string tag, input logic [15:0] a, input int len, input logic [2:0] sz,
                     input bit toggle, input logic [1:0] exp_resp);
      ARADDR = a; ARLEN = 8'(len); ARSIZE = sz; ARVALID = 1'b1; RREADY = 1'b0;
      chk({tag, " arready"}, 32'(ARREADY), 32'd1);
      tick();
      ARVALID = 1'b0;
      chk({tag, " rvalid_first"}, 32'(RVALID), 32'd1);
      for (int i = 0; i <= len; i++) begin
         if (toggle && (i % 2 == 0)) begin
            RREADY = 1'b0;
            tick();
            chk($sformatf("%s hold_v%0d", tag, i), 32'(RVALID), 32'd1);
            chk($sformatf("%s hold_d%0d", tag, i), RDATA, rx[i]);
         end
         RREADY = 1'b1;
         chk($sformatf("%s rvalid%0d", tag, i), 32'(RVALID), 32'd1);
         chk($sformatf("%s rdata%0d", tag, i), RDATA, rx[i]);
         chk($sformatf("%s rlast%0d", tag, i), 32'(RLAST), 32'(i == len));
         chk($sformatf("%s rresp%0d", tag, i), 32'(RRESP), 32'(exp_resp));
         tick();
      end
      RREADY = 1'b0;
      chk({tag, " rvalid_off"}, 32'(RVALID), 32'd0);
      chk({tag, " rlast_off"}, 32'(RLAST), 32'd0);
      chk({tag, " arready_back"}, 32'(ARREADY), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ARESETn = 1'b0;
      AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWVALID = 1'b0;
      WDATA = '0; WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b0;
      ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARVALID = 1'b0; RREADY = 1'b0;
      #12;
      chk("rst awready", 32'(AWREADY), 32'd1);
      chk("rst arready", 32'(ARREADY), 32'd1);
      chk("rst wready", 32'(WREADY), 32'd0);
      chk("rst bvalid", 32'(BVALID), 32'd0);
      chk("rst rvalid", 32'(RVALID), 32'd0);
      chk("rst rlast", 32'(RLAST), 32'd0);
      chk("rst bresp", 32'(BRESP), 32'd0);
      chk("rst rresp", 32'(RRESP), 32'd0);
      chk("rst rdata", RDATA, 32'd0);
      tick();
      ARESETn = 1'b1;
      tick();

      // 4-beat write and read back
      for (int i = 0; i < 4; i++) wd[i] = 32'hA0A0_0000 + 32'(i);
      wr("w4", 16'h0010, 3, 3'd2, -1, 2'b00);
      for (int i = 0; i < 4; i++) rx[i] = 32'hA0A0_0000 + 32'(i);
      rd("r4", 16'h0010, 3, 3'd2, 1'b0, 2'b00);

      // single beat
      wd[0] = 32'hDEAD_BEEF;
      wr("w1", 16'h0000, 0, 3'd2, -1, 2'b00);
      rx[0] = 32'hDEAD_BEEF;
      rd("r1", 16'h0000, 0, 3'd2, 1'b0, 2'b00);

      // 4 KB crossing: prior contents survive, read of same burst errors with zero data
      wd[0] = 32'h1111_2222;
      wr("wpre", 16'h0FFC, 0, 3'd2, -1, 2'b00);
      wd[0] = 32'h3333_4444; wd[1] = 32'h5555_6666;
      wr("wx4k", 16'h0FFC, 1, 3'd2, -1, 2'b10);
      rx[0] = 32'h1111_2222;
      rd("rpre", 16'h0FFC, 0, 3'd2, 1'b0, 2'b00);
      rx[0] = 32'h0; rx[1] = 32'h0;
      rd("rx4k", 16'h0FFC, 1, 3'd2, 1'b0, 2'b10);

      // misaligned, out of range, oversize
      wd[0] = 32'h0000_0BAD;
      wr("wmis", 16'h0012, 0, 3'd2, -1, 2'b10);
      wr("woor", 16'h1000, 0, 3'd2, -1, 2'b10);
      wr("wsz3", 16'h0020, 0, 3'd3, -1, 2'b10);
      rx[0] = 32'hA0A0_0000;
      rd("rmis", 16'h0010, 0, 3'd2, 1'b0, 2'b00);

      // 8-beat burst, streamed then with backpressure
      for (int i = 0; i < 8; i++) wd[i] = 32'h100 + 32'(i * 3);
      wr("w8", 16'h0100, 7, 3'd2, -1, 2'b00);
      for (int i = 0; i < 8; i++) rx[i] = 32'h100 + 32'(i * 3);
      rd("r8", 16'h0100, 7, 3'd2, 1'b0, 2'b00);
      rd("r8t", 16'h0100, 7, 3'd2, 1'b1, 2'b00);

      // early WLAST
      for (int i = 0; i < 4; i++) wd[i] = 32'hC0 + 32'(i);
      wr("wlast", 16'h0200, 3, 3'd2, 1, 2'b10);

      // reset during beat 2 of a write burst
      AWADDR = 16'h0300; AWLEN = 8'd3; AWSIZE = 3'd2; AWVALID = 1'b1;
      tick();
      AWVALID = 1'b0;
      for (int i = 0; i < 2; i++) begin
         WDATA = 32'h5500_0000 + 32'(i); WVALID = 1'b1; WLAST = 1'b0;
         tick();
      end
      WDATA = 32'h5500_0002; WVALID = 1'b1;
      #1 ARESETn = 1'b0;
      #1;
      chk("rst_mid wready", 32'(WREADY), 32'd0);
      chk("rst_mid awready", 32'(AWREADY), 32'd1);
      chk("rst_mid bvalid", 32'(BVALID), 32'd0);
      WVALID = 1'b0;
      tick();
      ARESETn = 1'b1;
      tick();
      wd[0] = 32'h7700_0000; wd[1] = 32'h7700_0001;
      wr("wpost", 16'h0400, 1, 3'd2, -1, 2'b00);
      rx[0] = 32'h5500_0000; rx[1] = 32'h5500_0001;
      rd("rabort", 16'h0300, 1, 3'd2, 1'b0, 2'b00);
      rx[0] = 32'h7700_0000; rx[1] = 32'h7700_0001;
      rd("rpost", 16'h0400, 1, 3'd2, 1'b0, 2'b00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/axi4_slave_mem.md
Name: axi4_slave_mem

Overview:
- AXI4 slave memory: the downstream target of the AXI4 stimulus driver.
- Accepts INCR write bursts into an internal word array and returns INCR read bursts from it.
- Write and read channels run as independent state machines on one clock.
- Each burst gets an OKAY/SLVERR response.

Parameters:
DATA_W, 32, data bus width in bits; fixed at 32
ADDR_W, 16, byte address width
MEM_DEPTH, 1024, number of DATA_W words in the array

Ports:
ACLK  input  1  clock; all sampling on rising edge
ARESETn  input  1  asynchronous active-low reset
AWADDR  input  ADDR_W  write burst start byte address
AWLEN  input  8  write beats minus one
AWSIZE  input  3  bytes per beat, log2
AWVALID  input  1  write address valid
AWREADY  output  1  write address ready
WDATA  input  DATA_W  write beat data
WVALID  input  1  write data valid
WLAST  input  1  final write beat marker
WREADY  output  1  write data ready
BRESP  output  2  write response: 00 OKAY, 10 SLVERR
BVALID  output  1  write response valid
BREADY  input  1  write response ready
ARADDR  input  ADDR_W  read burst start byte address
ARLEN  input  8  read beats minus one
ARSIZE  input  3  bytes per beat, log2
ARVALID  input  1  read address valid
ARREADY  output  1  read address ready
RDATA  output  DATA_W  read beat data
RRESP  output  2  read response
RLAST  output  1  final read beat marker
RVALID  output  1  read data valid
RREADY  input  1  read data ready

Behaviour:
- Clock ACLK; reset ARESETn is asynchronous and active-low.
- Reset values, applied immediately on ARESETn low:
  - AWREADY=1, ARREADY=1.
  - WREADY, BVALID, RVALID, RLAST = 0.
  - BRESP, RRESP, RDATA = 0.
  - Both FSMs go to IDLE.
  - Memory contents are not reset.
- Handshake: a transfer occurs on a rising edge where VALID and READY are both high.
- Once asserted, BVALID and RVALID (with their payloads) hold until their handshake.
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: AWREADY=1. On AW handshake, capture address, length and size; set beat count to 0; compute error flag; go to W_DATA.
  - W_DATA: AWREADY=0, WREADY=1.
    - Each W handshake writes WDATA to mem[addr>>2] unless the error flag is set.
    - Each beat advances addr by (1<<size) and increments the beat count.
  - On the beat where count==len, go to W_RESP.
  - WLAST mismatch sets SLVERR: WLAST high on an earlier beat, or low on the final beat. Beat counting still governs completion.
  - W_RESP: WREADY=0, BVALID=1, BRESP=SLVERR if error else OKAY. On B handshake go to W_IDLE; AWREADY=1 from the next cycle.
- Error conditions (SLVERR, no memory update for the whole burst):
  - size > 2;
  - start address not aligned to (1<<size);
  - last beat's word index >= MEM_DEPTH;
  - burst crosses a 4 KB boundary.
  - Data beats are still accepted and discarded.
- Read FSM, R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ARREADY=1. On AR handshake, capture the burst and compute the error flag with the same rules.
  - One cycle later: RVALID=1, RDATA=mem[start] (0 on error), RRESP, and RLAST=(len==0).
  - On each R handshake that is not the last beat, the same edge loads the next beat. RVALID stays high, giving back-to-back throughput of 1 beat/cycle.
  - On the last-beat handshake: RVALID=0, RLAST=0, return to R_IDLE.
- Read/write collision: a read beat loaded on the same edge as a write to the same word returns the old data. Channels are otherwise fully independent and may overlap.
- Address arithmetic is modulo 2^ADDR_W. Beat count is 9-bit, so AWLEN/ARLEN=255 gives 256 beats.
- Reset mid-burst: burst is abandoned with no response. Beats already written remain in memory.

Test Plan:
- Write AWADDR=0x0010, AWLEN=3, AWSIZE=2, data A0..A3 -> WREADY high for exactly 4 beats, then BVALID with BRESP=00. Read ARADDR=0x0010, ARLEN=3 -> first RVALID 1 cycle after AR handshake; RDATA A0,A1,A2,A3; RLAST only on the 4th beat; RRESP=00.
- Single-beat write with AWLEN=0 and WLAST=1 at 0x0000, data 0xDEADBEEF -> read back 0xDEADBEEF with RLAST on the first beat.
- Write at AWADDR=0x0FFC, AWLEN=1, crossing 4 KB -> BRESP=10, and a read of 0x0FFC returns the prior contents. Read of the same burst -> RRESP=10, RDATA=0 on both beats.
- RREADY held high for an 8-beat read -> 8 consecutive cycles of RVALID with incrementing data. RREADY toggled -> RVALID/RDATA hold stable while RREADY is low.
- WLAST asserted on beat 1 of a 4-beat burst -> all 4 beats accepted, BRESP=10.
- ARESETn pulsed low during W_DATA beat 2 -> WREADY=0 and AWREADY=1 immediately. A new burst then completes with OKAY, and beats 0-1 of the aborted burst are readable.
